// File: rtl/fp32_add_arbiter.sv
// Round-robin arbiter sharing one combinational FP32 truncating adder among NUM_REQ requesters.
// Latency: one cycle from request transfer to registered response.
// Backpressure: while the response register is full and not being popped, all req_ready stay low.

// Combinational FP32 add, round-toward-zero, denormal inputs flushed to zero,
// NaN in (or inf minus inf) gives quiet NaN 0x7FC00000, overflow saturates to max finite.
module fp32_add (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  logic              sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap;
  logic              big_s, small_s, sticky;
  logic [7:0]        ea, eb, big_e, small_e, d;
  logic [22:0]       fa, fb;
  logic [23:0]       big_m, small_m, mant;
  logic [26:0]       small_ext, aligned, mask;
  logic [27:0]       big_x, raw, norm;
  logic [4:0]        pos, lsh;
  logic signed [9:0] exp_r;
  logic [31:0]       norm_res;

  // Align, add/subtract with a sticky borrow, normalize, truncate, then override specials.
  always_comb begin
    sa = a[31];
    sb = b[31];
    ea = a[30:23];
    eb = b[30:23];
    fa = a[22:0];
    fb = b[22:0];
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);

    // Larger magnitude goes first so the subtraction never goes negative.
    swap    = {eb, fb} > {ea, fa};
    big_s   = swap ? sb : sa;
    small_s = swap ? sa : sb;
    big_e   = swap ? eb : ea;
    small_e = swap ? ea : eb;
    big_m   = swap ? {1'b1, fb} : {1'b1, fa};
    small_m = swap ? {1'b1, fa} : {1'b1, fb};
    d       = big_e - small_e;

    // Three extra low bits; anything shifted past them only matters as a borrow.
    small_ext = {small_m, 3'b000};
    if (d >= 8'd27) begin
      mask    = '0;
      aligned = '0;
      sticky  = 1'b1;
    end else begin
      mask    = (27'd1 << d[4:0]) - 27'd1;
      aligned = small_ext >> d[4:0];
      sticky  = |(small_ext & mask);
    end

    big_x = {1'b0, big_m, 3'b000};
    if (big_s != small_s) begin
      raw = big_x - {1'b0, aligned} - {27'd0, sticky};
    end else begin
      raw = big_x + {1'b0, aligned};
    end

    pos = '0;
    for (int i = 0; i < 28; i++) begin
      if (raw[i]) begin
        pos = 5'(i);
      end
    end

    lsh = '0;
    if (pos == 5'd27) begin
      norm  = raw >> 1;
      exp_r = $signed({2'b00, big_e}) + 10'sd1;
    end else begin
      lsh   = 5'd26 - pos;
      norm  = raw << lsh;
      exp_r = $signed({2'b00, big_e}) - $signed({5'd0, lsh});
    end
    mant = norm[26:3];

    if (raw == 28'd0) begin
      norm_res = 32'd0;
    end else if (exp_r >= 10'sd255) begin
      norm_res = {big_s, 31'h7F7FFFFF};
    end else if (exp_r <= 10'sd0) begin
      norm_res = {big_s, 31'd0};
    end else begin
      norm_res = {big_s, exp_r[7:0], mant[22:0]};
    end

    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      sum = 32'h7FC00000;
    end else if (a_inf) begin
      sum = {sa, 8'hFF, 23'd0};
    end else if (b_inf) begin
      sum = {sb, 8'hFF, 23'd0};
    end else if (a_zero && b_zero) begin
      sum = {sa & sb, 31'd0};
    end else if (a_zero) begin
      sum = b;
    end else if (b_zero) begin
      sum = a;
    end else begin
      sum = norm_res;
    end
  end

endmodule

module fp32_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_sum,
  output logic [ID_W-1:0]       rsp_id
);

  logic [ID_W-1:0] ptr, gnt_idx, idx_hi, idx_any, sel;
  logic            found_hi, slot_free, grant;
  logic [31:0]     op_a, op_b, add_sum;

  // Round-robin search: lowest valid port at or above ptr, else lowest valid port overall.
  always_comb begin
    found_hi = 1'b0;
    idx_hi   = ptr;
    idx_any  = ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        idx_any = ID_W'(i);
        if (ID_W'(i) >= ptr) begin
          found_hi = 1'b1;
          idx_hi   = ID_W'(i);
        end
      end
    end
    gnt_idx   = found_hi ? idx_hi : idx_any;
    slot_free = !rsp_valid || rsp_ready;
    grant     = slot_free && (|req_valid) && !rst;
    sel       = grant ? gnt_idx : ptr;
  end

  // One-hot ready for the granted port and operand mux into the shared adder.
  always_comb begin
    req_ready = '0;
    op_a      = '0;
    op_b      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant && (gnt_idx == ID_W'(i));
      if (sel == ID_W'(i)) begin
        op_a = req_a[32*i +: 32];
        op_b = req_b[32*i +: 32];
      end
    end
  end

  fp32_add u_add (
    .a   (op_a),
    .b   (op_b),
    .sum (add_sum)
  );

  // Response register and pointer: load on transfer, clear valid on a pop without refill.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_sum   <= '0;
      rsp_id    <= '0;
    end else if (grant) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= add_sum;
      rsp_id    <= gnt_idx;
      ptr       <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp32_add_arbiter.sv
// Bench for fp32_add_arbiter: directed steps for reset, grant order, backpressure,
// pop/push overlap and mid-run reset, then a randomized queue-based scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are sampled 4 units after it.
module tb_fp32_add_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_a, req_b;
  logic         rsp_ready, rsp_valid;
  logic [31:0]  rsp_sum;
  logic [1:0]   rsp_id;

  logic [2:0]   v3, rdy3;
  logic [95:0]  a3, b3;
  logic         rr3, rv3;
  logic [31:0]  rs3;
  logic [1:0]   ri3;

  fp32_add_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_sum(rsp_sum), .rsp_id(rsp_id)
  );

  fp32_add_arbiter #(.NUM_REQ(3), .ID_W(2)) dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_a(a3), .req_b(b3),
    .req_ready(rdy3), .rsp_valid(rv3), .rsp_ready(rr3),
    .rsp_sum(rs3), .rsp_id(ri3)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [31:0] sum;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  // Exact sum of two normal floats as scaled integers, then truncated to 24 bits.
  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b);
    int           ea, eb, emin, p, e;
    logic [127:0] va, vb, mag, mant;
    logic         sign;
    ea   = int'(a[30:23]);
    eb   = int'(b[30:23]);
    emin = (ea < eb) ? ea : eb;
    va   = {104'd0, 1'b1, a[22:0]} << (ea - emin);
    vb   = {104'd0, 1'b1, b[22:0]} << (eb - emin);
    if (a[31] == b[31]) begin
      mag  = va + vb;
      sign = a[31];
    end else if (va >= vb) begin
      mag  = va - vb;
      sign = a[31];
    end else begin
      mag  = vb - va;
      sign = b[31];
    end
    if (mag == 128'd0) return 32'd0;
    p = 0;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    if (p >= 23) mant = mag >> (p - 23);
    else         mant = mag << (23 - p);
    e = emin + p - 23;
    return {sign, 8'(e), mant[22:0]};
  endfunction

  function automatic logic [31:0] rand_normal();
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
    s = 1'($urandom);
    e = 8'($urandom_range(154, 100));
    f = 23'($urandom);
    return {s, e, f};
  endfunction

  logic [31:0] pa [4];
  logic [31:0] pb [4];
  bit   [3:0]  pend;
  int          mptr, g;

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    v3 = '0; a3 = '0; b3 = '0; rr3 = 1'b1;
    pend = '0;

    // Reset: no grants while rst is high, even with requests pending.
    cyc(); req_valid = 4'hF; v3 = 3'b111;
    settle();
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_ready3", 32'(rdy3), 32'h0);
    cyc(); rst = 1'b0; req_valid = '0; v3 = '0;
    settle();
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_sum", rsp_sum, 32'h0);
    chk("rst_id", 32'(rsp_id), 32'h0);
    chk("rst_valid3", 32'(rv3), 32'h0);

    // Single requester on port 2: 1.0 + 2.0.
    cyc(); set_op(2, 32'h3F800000, 32'h40000000); req_valid = 4'b0100; rsp_ready = 1'b1;
    settle();
    chk("single_ready", 32'(req_ready), 32'h4);
    cyc(); req_valid = '0;
    settle();
    chk("single_valid", 32'(rsp_valid), 32'h1);
    chk("single_sum", rsp_sum, 32'h40400000);
    chk("single_id", 32'(rsp_id), 32'h2);
    // Pointer now 3: ports 0 and 3 pending must pick 3 first, then wrap to 0.
    cyc(); set_op(0, 32'h3F800000, 32'h3F800000); set_op(3, 32'h3F800000, 32'h3F800000);
    req_valid = 4'b1001;
    settle();
    chk("ptr3_ready", 32'(req_ready), 32'h8);
    cyc(); req_valid = 4'b0001;
    settle();
    chk("wrap_ready", 32'(req_ready), 32'h1);
    chk("wrap_prev_id", 32'(rsp_id), 32'h3);
    cyc(); req_valid = '0;
    settle();

    // Round robin from a fresh reset, NUM_REQ=4 and NUM_REQ=3 side by side.
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0; req_valid = 4'hF; v3 = 3'b111;
    for (int i = 0; i < 4; i++) set_op(i, 32'h3F800000, 32'h3F800000);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) cyc();
      settle();
      chk("rr_ready", 32'(req_ready), 32'(1 << (k % 4)));
      chk("rr3_ready", 32'(rdy3), 32'(1 << (k % 3)));
      if (k > 0) begin
        chk("rr_id", 32'(rsp_id), 32'((k - 1) % 4));
        chk("rr3_id", 32'(ri3), 32'((k - 1) % 3));
        chk("rr_valid", 32'(rsp_valid), 32'h1);
      end
    end
    cyc(); req_valid = '0; v3 = '0;
    settle();
    chk("rr_last_id", 32'(rsp_id), 32'h1);

    // Backpressure: port 1 result (1.5+2.5) held for 5 cycles while ports 0 and 3 wait.
    cyc(); set_op(1, 32'h3FC00000, 32'h40200000); req_valid = 4'b0010;
    settle();
    chk("bp_grant1", 32'(req_ready), 32'h2);
    cyc(); set_op(0, 32'h40A00000, 32'h00000000); set_op(3, 32'h3F800000, 32'h3F800000);
    req_valid = 4'b1001; rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) cyc();
      settle();
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_sum", rsp_sum, 32'h40800000);
      chk("bp_id", 32'(rsp_id), 32'h1);
      chk("bp_ready", 32'(req_ready), 32'h0);
    end
    cyc(); rsp_ready = 1'b1;
    settle();
    chk("bp_release_ready", 32'(req_ready), 32'h8);
    chk("bp_release_sum", rsp_sum, 32'h40800000);
    // Pop and push together: port 0 granted while port 3 result is popped.
    cyc(); req_valid = 4'b0001;
    settle();
    chk("bp3_sum", rsp_sum, 32'h40000000);
    chk("bp3_id", 32'(rsp_id), 32'h3);
    chk("pp_ready", 32'(req_ready), 32'h1);
    cyc(); set_op(1, 32'h3FC00000, 32'h40200000); req_valid = 4'b0010;
    settle();
    chk("pp_valid", 32'(rsp_valid), 32'h1);
    chk("pp_sum", rsp_sum, 32'h40A00000);
    chk("pp_id", 32'(rsp_id), 32'h0);
    chk("pp_next_ready", 32'(req_ready), 32'h2);

    // Reset with a full response register and ptr=2.
    cyc(); rst = 1'b1; req_valid = 4'hF;
    settle();
    chk("mrst_ready0", 32'(req_ready), 32'h0);
    chk("mrst_held", 32'(rsp_valid), 32'h1);
    cyc();
    settle();
    chk("mrst_valid", 32'(rsp_valid), 32'h0);
    chk("mrst_ready1", 32'(req_ready), 32'h0);
    cyc(); rst = 1'b0;
    settle();
    chk("mrst_first", 32'(req_ready), 32'h1);
    cyc(); req_valid = '0;
    settle();
    chk("mrst_id", 32'(rsp_id), 32'h0);
    cyc();
    settle();
    chk("idle_valid", 32'(rsp_valid), 32'h0);

    // Randomized scoreboard; requests stop after 600 cycles and the channel drains.
    mptr = 1;
    for (int n = 0; n < 615; n++) begin
      cyc();
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && n < 600 && $urandom_range(2, 0) == 0) begin
          pend[i] = 1'b1;
          pa[i]   = rand_normal();
          if ($urandom_range(3, 0) == 0) pb[i] = {~pa[i][31], pa[i][30:8], 8'($urandom)};
          else                           pb[i] = rand_normal();
        end
        req_valid[i] = pend[i];
        if (pend[i]) set_op(i, pa[i], pb[i]);
      end
      rsp_ready = (n >= 600) ? 1'b1 : ($urandom_range(3, 0) != 0);
      settle();
      g = -1;
      if (q.size() == 0 || rsp_ready) begin
        for (int k = 0; k < 4; k++) begin
          if (g < 0 && pend[(mptr + k) % 4]) g = (mptr + k) % 4;
        end
      end
      chk("rand_ready", 32'(req_ready), (g >= 0) ? 32'(1 << g) : 32'h0);
      if (q.size() > 0) begin
        chk("rand_valid", 32'(rsp_valid), 32'h1);
        chk("rand_sum", rsp_sum, q[0].sum);
        chk("rand_id", 32'(rsp_id), 32'(q[0].id));
      end else begin
        chk("rand_idle", 32'(rsp_valid), 32'h0);
      end
      if (rsp_ready && q.size() > 0) void'(q.pop_front());
      if (g >= 0) begin
        q.push_back('{g, fp_model(pa[g], pb[g])});
        pend[g] = 1'b0;
        mptr    = (g + 1) % 4;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp32_add_arbiter.md
# fp32_add_arbiter

Shares one combinational `fp32_add` instance among `NUM_REQ` requesters, such as accumulation lanes or reduction stages that each need occasional FP32 adds. Arbitration is round-robin. Each requester uses a valid/ready handshake. Every sum is registered and returned on a single response channel, tagged with the ID of the requester that issued it. Arithmetic follows `fp32_add` exactly (truncating, with its special-case handling); this block adds only sequencing, fairness and backpressure.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `ID_W`, default 2: width of the response ID; must equal max(1, $clog2(NUM_REQ)).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req_valid`  in  NUM_REQ  bit i: requester i has an add pending.
- `req_a`  in  NUM_REQ*32  operand A; requester i occupies bits [32*i+31 : 32*i].
- `req_b`  in  NUM_REQ*32  operand B; same packing as `req_a`.
- `req_ready`  out  NUM_REQ  one-hot or zero; bit i high means requester i is accepted this cycle.
- `rsp_valid`  out  1  the response register holds a result.
- `rsp_ready`  in  1  the consumer accepts the response this cycle.
- `rsp_sum`  out  32  FP32 sum, `fp32_add(req_a[i], req_b[i])`.
- `rsp_id`  out  ID_W  index of the requester that produced `rsp_sum`.

## Operation
State elements:
- Round-robin pointer `ptr` (ID_W bits); reset value 0.
- Response register: `rsp_valid`, `rsp_sum`, `rsp_id`; all reset to 0.

Response slot:
- `slot_free = !rsp_valid || rsp_ready`.

Grant (combinational):
- When `slot_free`, grant the first i with `req_valid[i]=1`, searching i = ptr, ptr+1, ..., wrapping modulo NUM_REQ.
- Assert `req_ready[i]` for that i only.
- When `!slot_free`, or when no request is valid, `req_ready` is all zero.

Handshake:
- A transfer on port i occurs when `req_valid[i] && req_ready[i]`.
- A requester holds `req_valid`, `req_a` and `req_b` stable until its transfer.
- Deasserting valid before transfer is illegal.
- `req_ready` may depend combinationally on `req_valid`, `ptr`, `rsp_valid` and `rsp_ready`.
- `req_valid` must not depend on `req_ready`.

Shared adder:
- The adder inputs are muxed from the granted port.
- When there is no grant, the mux selects port `ptr`; the result is discarded.

On a transfer from port g:
- `rsp_sum <= fp32_add(a_g, b_g)`, `rsp_id <= g`, `rsp_valid <= 1`.
- `ptr <= (g+1) mod NUM_REQ`; with NUM_REQ not a power of two, g = NUM_REQ-1 wraps to 0.

On `rsp_valid && rsp_ready` with no new transfer:
- `rsp_valid <= 0`; `rsp_sum` and `rsp_id` hold their values.

Simultaneous response pop and new transfer:
- The register is overwritten with the new result.
- `rsp_valid` stays 1; there is no bubble.

With no transfer, `ptr` holds.

## Timing
- Latency: a transfer in cycle N gives `rsp_valid=1` with its result in cycle N+1.
- Throughput: one add per cycle while `rsp_ready=1`.
- Fairness: a continuously valid requester is granted within NUM_REQ slot-free cycles.
- Backpressure: while `rsp_valid=1 && rsp_ready=0`:
  - the response register, `ptr` and all `req_ready` bits are frozen (register and `ptr`) or 0 (`req_ready`);
  - no result is ever dropped or duplicated.
- Reset:
  - `rst` sampled high clears `ptr` and `rsp_valid` at that edge, discarding any pending response.
  - `req_ready` is 0 during every cycle in which `rst` is high.
  - Arbitration starts at port 0 in the first cycle after `rst` falls.

## Test plan
- Single requester:
  - stimulus: port 2 valid with a=0x3F800000 (1.0), b=0x40000000 (2.0), `rsp_ready`=1;
  - response: `req_ready`=4'b0100 in cycle N; in N+1 `rsp_valid`=1, `rsp_sum`=0x40400000, `rsp_id`=2; `ptr`=3.
- Round-robin with wrap:
  - stimulus: all 4 ports valid continuously, `rsp_ready`=1;
  - response: grant order 0,1,2,3,0,1; `rsp_id` follows one cycle later.
  - repeat with NUM_REQ=3: order 0,1,2,0.
- Backpressure:
  - stimulus: port 1 with 1.5+2.5 (0x3FC00000, 0x40200000) is granted, then `rsp_ready`=0 for 5 cycles while ports 0 and 3 are valid;
  - response: `rsp_sum`=0x40800000 held, `req_ready`=0 throughout;
  - then `rsp_ready`=1: port 3 is granted first (ptr=2 searches 2, 3), then port 0.
- Pop and push in the same cycle:
  - stimulus: `rsp_valid`=1, `rsp_ready`=1, port 0 valid with a=0x40A00000, b=0x00000000;
  - response: `rsp_valid` stays 1; next `rsp_sum`=0x40A00000, `rsp_id`=0.
- Reset mid-operation:
  - stimulus: `rst`=1 while `rsp_valid`=1 and ptr=2;
  - response: next cycle `rsp_valid`=0, `req_ready`=0; after reset with all ports valid, port 0 is granted first.
- Scoreboard (random):
  - stimulus: random valid/operands (normal values only) and random `rsp_ready`;
  - response: every accepted request appears exactly once on the response channel with the correct `rsp_id`, and `rsp_sum` bit-matches a standalone `fp32_add` model.
